// File: rtl/dpram_stream_pkg.sv
// rtl/dpram_stream_pkg.sv - shared types and helpers for the dual-port RAM read streamer
// Contents:
//   state_t  burst engine state (IDLE, ISSUE, DRAIN)
//   clog2    counter-width helper, never returns less than 1
package dpram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - small register FIFO used as the read-return buffer
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears pointers and count)
//   push, din    write side; push while full is taken only together with a pop
//   pop, dout    read side; dout is the head entry, valid while !empty
//   count        current occupancy (0..DEPTH)
//   full, empty  occupancy flags
module stream_fifo
  import dpram_stream_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic [clog2(DEPTH+1)-1:0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dpram_read_streamer.sv
// rtl/dpram_read_streamer.sv - burst read engine turning a RAM port into a valid/ready stream
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr/req_len  burst request (len = words-1), accepted only in IDLE
//   ram_en/ram_addr/ram_dout          RAM read port, data returns LATENCY cycles after ram_en
//   out_valid/out_ready/out_data/out_last  return stream, last marks the final word
//   busy                              high while a burst is issuing or draining
module dpram_read_streamer
  import dpram_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  parameter  int LATENCY    = 1,
  parameter  int LEN_W      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_addr,
  input  logic [LEN_W-1:0]      req_len,
  output logic                  ram_en,
  output logic [AW-1:0]         ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int FIFO_DEPTH = LATENCY + 2;
  localparam int IFW        = clog2(LATENCY + 1);
  localparam int FCW        = clog2(FIFO_DEPTH + 1);
  localparam int OCW        = FCW + 1;

  state_t               state;
  state_t               state_nxt;
  logic [AW-1:0]        addr;
  logic [AW-1:0]        addr_inc;
  logic [LEN_W-1:0]     remaining;
  logic [IFW-1:0]       inflight;
  logic [LATENCY-1:0]   tag_valid;
  logic [LATENCY-1:0]   tag_last;
  logic [FCW-1:0]       fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_WIDTH:0]  fifo_dout;
  logic                 push;
  logic                 pop;
  logic [OCW-1:0]       occupancy;
  logic                 has_credit;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign ram_addr  = addr;
  assign addr_inc  = (addr == AW'(DEPTH-1)) ? '0 : addr + AW'(1);

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_dout[DATA_WIDTH-1:0];
  assign out_last  = fifo_dout[DATA_WIDTH];
  assign pop       = out_valid && out_ready;
  assign push      = tag_valid[LATENCY-1];

  // Every word already issued or buffered owns a FIFO slot; a pop this cycle
  // frees its slot in time for a read issued in the same cycle.
  assign occupancy  = OCW'(inflight) + OCW'(fifo_count);
  assign has_credit = occupancy < (OCW'(FIFO_DEPTH) + OCW'(pop));

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        ram_en = has_credit;
        if (has_credit && (remaining == '0)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((inflight == '0) && fifo_empty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= '0;
      tag_valid <= '0;
      tag_last  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && req_valid) begin
        addr      <= req_addr;
        remaining <= req_len;
      end else if (ram_en) begin
        addr <= addr_inc;
        if (remaining != '0) remaining <= remaining - LEN_W'(1);
      end
      // Tags travel alongside the RAM's read pipeline so returned data is
      // recognised without the RAM reporting validity itself.
      tag_valid[0] <= ram_en;
      tag_last[0]  <= ram_en && (remaining == '0);
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      case ({ram_en, push})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({tag_last[LATENCY-1], ram_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_dpram_read_streamer.sv
// tb/tb_dpram_read_streamer.sv - self-checking bench for dpram_read_streamer with a latency-3 RAM model
module tb_dpram_read_streamer;

  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int LAT   = 3;
  localparam int LEN_W = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int FD    = LAT + 2;
  localparam int MAXC  = 2000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AW-1:0]    req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic             ram_en;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_dout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_read_streamer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .LATENCY    (LAT),
    .LEN_W      (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Behavioural RAM port: mem[i] = i, read data LAT cycles after ram_en; not reset.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [LAT];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = i;
  always @(posedge clk) begin
    rd_pipe[0] <= ram_en ? mem[ram_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[LAT-1];

  // Observations of the most recent burst.
  int got_data[$];
  bit got_last[$];
  int first_valid_c, first_beat_c, last_beat_c;
  int stall_viol, issues_stalled, rr_err;
  bit timed_out;

  // Reference model: word i of a burst is (addr+i) mod DEPTH, last only on i==len.
  // Returns the first index that disagrees with the collected beats, or -1.
  function automatic int model_first_bad(input int addr, input int len);
    if (got_data.size() != len + 1) return -2;
    for (int i = 0; i <= len; i++) begin
      if (got_data[i] != (addr + i) % DEPTH) return i;
      if (got_last[i] != (i == len)) return i;
    end
    return -1;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge just after acceptance.
  task automatic send_req(input int addr, input int len);
    req_addr  = AW'(addr);
    req_len   = LEN_W'(len);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Drives out_ready (held low for stall_cycles, then ready_pct % random) and
  // records beats until the engine is idle again. Cycle 0 is the half-cycle after accept.
  task automatic collect(input int stall_cycles, input int ready_pct);
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    int            c;
    got_data.delete();
    got_last.delete();
    first_valid_c = -1; first_beat_c = -1; last_beat_c = -1;
    stall_viol = 0; issues_stalled = 0; rr_err = 0;
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (c = 0; c < MAXC; c++) begin
      if (prev_stall && (!out_valid || out_data !== prev_d || out_last !== prev_l)) stall_viol++;
      if (req_ready === busy) rr_err++;
      if (!busy && !out_valid) break;
      if (out_valid && first_valid_c < 0) first_valid_c = c;
      out_ready = (c >= stall_cycles) && (int'($urandom_range(99)) < ready_pct);
      #1;
      if (ram_en && c < stall_cycles) issues_stalled++;
      if (out_valid && out_ready) begin
        got_data.push_back(int'(out_data));
        got_last.push_back(out_last);
        if (first_beat_c < 0) first_beat_c = c;
        last_beat_c = c;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      @(negedge clk);
    end
    timed_out = (c >= MAXC);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready, ram_en, out_valid, out_last, busy} !== 5'b10000 || ram_addr !== '0) begin
      errors++;
      $display("FAIL reset_values: got rdy/en/vld/last/busy=%b addr=%0d expected 10000 addr=0",
               {req_ready, ram_en, out_valid, out_last, busy}, ram_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bad;
    send_req(5, 3);
    collect(0, 100);
    bad = model_first_bad(5, 3);
    checks++;
    if (timed_out || bad != -1) begin
      errors++;
      $display("FAIL basic_seq: got bad_index=%0d beats=%0d expected -1 beats=4", bad, got_data.size());
    end
    checks++;
    if (first_valid_c != LAT + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected %0d", first_valid_c, LAT + 1);
    end
    checks++;
    if (last_beat_c - first_beat_c != 3) begin
      errors++;
      $display("FAIL basic_throughput: got span %0d expected 3", last_beat_c - first_beat_c);
    end
    checks++;
    if (req_ready !== 1'b1 || rr_err != 0) begin
      errors++;
      $display("FAIL basic_req_ready: got %b (mismatch cycles %0d) expected 1 (0)", req_ready, rr_err);
    end
  endtask

  task automatic test_wrap();
    int bad;
    send_req(DEPTH - 2, 3);
    collect(0, 100);
    bad = model_first_bad(DEPTH - 2, 3);
    checks++;
    if (timed_out || bad != -1) begin
      errors++;
      $display("FAIL wrap_seq: got bad_index=%0d beats=%0d expected -1 beats=4", bad, got_data.size());
    end
  endtask

  task automatic test_backpressure();
    int bad;
    int a;
    a = int'($urandom_range(DEPTH - 1));
    send_req(a, 15);
    collect(20, 100);
    checks++;
    if (issues_stalled != FD) begin
      errors++;
      $display("FAIL stall_issues: got %0d expected %0d", issues_stalled, FD);
    end
    bad = model_first_bad(a, 15);
    checks++;
    if (timed_out || bad != -1) begin
      errors++;
      $display("FAIL stall_seq: got bad_index=%0d beats=%0d expected -1 beats=16", bad, got_data.size());
    end
  endtask

  task automatic test_random_ready();
    int bad;
    int a;
    int nlast;
    for (int rep = 0; rep < 3; rep++) begin
      a = int'($urandom_range(DEPTH - 1));
      send_req(a, 31);
      collect(0, 50);
      bad = model_first_bad(a, 31);
      nlast = 0;
      foreach (got_last[i]) nlast += int'(got_last[i]);
      checks++;
      if (timed_out || bad != -1 || nlast != 1) begin
        errors++;
        $display("FAIL random_seq: got bad_index=%0d beats=%0d lasts=%0d expected -1 32 1",
                 bad, got_data.size(), nlast);
      end
      checks++;
      if (stall_viol != 0) begin
        errors++;
        $display("FAIL random_stable: got %0d unstable stalls expected 0", stall_viol);
      end
    end
  endtask

  task automatic test_reset_midburst();
    int n;
    int stray;
    int bad;
    n = 0;
    out_ready = 1'b1;
    send_req(int'($urandom_range(DEPTH - 1)), 15);
    for (int c = 0; c < 100 && n < 4; c++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, ram_en, out_valid, out_last, busy} !== 5'b10000 || ram_addr !== '0 || n != 4) begin
      errors++;
      $display("FAIL midburst_reset: got rdy/en/vld/last/busy=%b addr=%0d beats=%0d expected 10000 0 4",
               {req_ready, ram_en, out_valid, out_last, busy}, ram_addr, n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      if (out_valid || busy) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midburst_stray: got %0d active cycles expected 0", stray);
    end
    send_req(0, 0);
    collect(0, 100);
    bad = model_first_bad(0, 0);
    checks++;
    if (timed_out || bad != -1) begin
      errors++;
      $display("FAIL post_reset_seq: got bad_index=%0d beats=%0d expected -1 beats=1", bad, got_data.size());
    end
  endtask

  task automatic test_back_to_back();
    int a;
    int bad;
    for (int k = 0; k < 4; k++) begin
      a = int'($urandom_range(DEPTH - 1));
      send_req(a, 0);
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept: got req_ready=%b busy=%b expected 0 1", req_ready, busy);
      end
      collect(0, 100);
      bad = model_first_bad(a, 0);
      checks++;
      if (timed_out || bad != -1 || rr_err != 0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_seq: got bad_index=%0d beats=%0d rr_err=%0d req_ready=%b expected -1 1 0 1",
                 bad, got_data.size(), rr_err, req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_random_ready();
    test_reset_midburst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
